// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer with memory handshake, timeout trap and retire counter
module mc_ctrl_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_res,
  output logic             mem_to_reg,
  output logic             shf_to_reg,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       jump,
  output logic             branch_taken,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } stateT;
  stateT           cur;
  logic [5:0]      opQ, funcQ, iop, ifn;
  logic [TO_W-1:0] waitCnt;
  logic            isR, isAdd, isSub, isJr, isNop, isOri, isLw, isSw, isBeq, isLui, isJal;
  logic            legal, sel, act, timeout, retire;
  // The IR is only guaranteed stable from DECODE on, so decode live op/func there and the latched copy afterwards.
  assign iop     = (cur == DECODE) ? op : opQ;
  assign ifn     = (cur == DECODE) ? func : funcQ;
  assign isR     = iop == 6'b000000;
  assign isAdd   = isR && ifn == 6'b100000;
  assign isSub   = isR && ifn == 6'b100010;
  assign isJr    = isR && ifn == 6'b001000;
  assign isNop   = isR && !isAdd && !isSub && !isJr;
  assign isOri   = iop == 6'b001101;
  assign isLw    = iop == 6'b100011;
  assign isSw    = iop == 6'b101011;
  assign isBeq   = iop == 6'b000100;
  assign isLui   = iop == 6'b001111;
  assign isJal   = iop == 6'b000011;
  assign legal   = isR || isOri || isLw || isSw || isBeq || isLui || isJal;
  assign sel     = cur == EXEC || cur == MEM || cur == WB;
  assign act     = !reset;
  assign timeout = MEM_TIMEOUT != 0 && waitCnt == TO_W'(MEM_TIMEOUT) && !mem_ready;
  assign retire  = (cur == DECODE && (isNop || isJr || isJal)) || (cur == EXEC && isBeq) ||
                   (cur == MEM && mem_ready && isSw) || cur == WB;
  // Strobes are suppressed while reset is asserted; datapath selects follow the latched instruction.
  always_comb begin
    mem_req      = act && (cur == FETCH || cur == MEM);
    mem_we       = act && cur == MEM && isSw;
    ir_write     = act && cur == FETCH && mem_ready;
    pc_write     = act && ((cur == FETCH && mem_ready) || (cur == DECODE && (isJr || isJal)) ||
                           (cur == EXEC && isBeq && zero));
    branch_taken = act && cur == EXEC && isBeq && zero;
    reg_write    = act && (cur == WB || (cur == DECODE && isJal));
    jump         = (act && cur == DECODE) ? (isJr ? 2'b01 : isJal ? 2'b10 : 2'b00) : 2'b00;
    reg_dst      = sel && (isAdd || isSub);
    alu_src      = sel && (isOri || isLw || isSw);
    ext_res      = sel && isOri;
    mem_to_reg   = sel && (isAdd || isSub || isOri);
    shf_to_reg   = sel && isLui;
    alu_op       = !sel ? 2'b00 : (isSub || isBeq) ? 2'b01 : isOri ? 2'b11 : 2'b00;
  end
  assign state   = cur;
  assign illegal = cur == TRAP;
  // Sequencer: state transitions, IR latch, memory wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      opQ     <= '0;
      funcQ   <= '0;
      waitCnt <= '0;
      retired <= '0;
    end else begin
      if (cur == DECODE) begin
        opQ   <= op;
        funcQ <= func;
      end
      waitCnt <= ((cur == FETCH || cur == MEM) && !mem_ready) ? waitCnt + TO_W'(1) : '0;
      if (retire) retired <= retired + CNT_W'(1);
      case (cur)
        FETCH, MEM: if (timeout) cur <= TRAP;
                    else if (mem_ready) cur <= (cur == FETCH) ? DECODE : isLw ? WB : FETCH;
        DECODE:     cur <= !legal ? TRAP : (isNop || isJr || isJal) ? FETCH : EXEC;
        EXEC:       cur <= isBeq ? FETCH : (isLw || isSw) ? MEM : WB;
        WB:         cur <= FETCH;
        default:    cur <= TRAP;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized scoreboard bench for the multi-cycle control sequencer
module tb_mc_ctrl_fsm;
  localparam int CW = 2;
  localparam int MT = 4;
  localparam int ADD = 0, SUB = 1, JR = 2, NOP = 3, ORI = 4, LW = 5, SW = 6, BEQ = 7, LUI = 8, JAL = 9, ILL = 10;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] op, func;
  logic pc_write, ir_write, mem_req, mem_we, reg_dst, alu_src, ext_res, mem_to_reg, shf_to_reg;
  logic reg_write, branch_taken, illegal;
  logic [1:0] alu_op, jump;
  logic [2:0] state;
  logic [CW-1:0] retired;

  mc_ctrl_fsm #(.CNT_W(CW), .MEM_TIMEOUT(MT), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
    .reg_dst(reg_dst), .alu_src(alu_src), .ext_res(ext_res), .mem_to_reg(mem_to_reg),
    .shf_to_reg(shf_to_reg), .alu_op(alu_op), .reg_write(reg_write), .jump(jump),
    .branch_taken(branch_taken), .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          chkSel;
    logic [2:0]    st;
    logic [7:0]    strb;
    logic [6:0]    sl;
    logic [CW-1:0] ret;
    logic          ill;
  } recT;

  recT expQ[$];
  int  nChk = 0;
  int  nFail = 0;
  int  mRet = 0;

  logic [5:0] opc [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h03};
  logic [5:0] fnc [3]  = '{6'h20, 6'h22, 6'h08};
  logic [6:0] selT [10] = '{7'b1001000, 7'b1001001, 7'b0, 7'b0, 7'b0111011,
                            7'b0100000, 7'b0100000, 7'b0000001, 7'b0000100, 7'b0};

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] sb(input logic rq, we, iw, pw, rw, bt, input logic [1:0] j);
    return {rq, we, iw, pw, rw, bt, j};
  endfunction

  function automatic logic [5:0] illOp();
    logic [5:0] o;
    do o = r6();
    while (o == 6'h00 || o == 6'h0d || o == 6'h23 || o == 6'h2b || o == 6'h04 || o == 6'h0f || o == 6'h03);
    return o;
  endfunction

  function automatic logic [5:0] nopFn();
    logic [5:0] f;
    do f = r6();
    while (f == 6'h20 || f == 6'h22 || f == 6'h08);
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    nChk++;
    if (a !== x) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, x);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show during that cycle.
  task automatic push(input logic rs, rd, zz, input logic [5:0] o, f, input logic [2:0] st,
                      input logic [7:0] strb, input logic [6:0] sl);
    recT r;
    r.chkSel = !rs && st >= 3'd2 && st <= 3'd4;
    r.st     = st;
    r.strb   = strb;
    r.sl     = sl;
    r.ret    = CW'(mRet % (1 << CW));
    r.ill    = st == 3'd5;
    reset = rs; mem_ready = rd; zero = zz; op = o; func = f;
    expQ.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut(input logic [2:0] stNow);
    push(1'b1, r1(), r1(), r6(), r6(), stNow, 8'h00, 7'b0);
    mRet = 0;
    push(1'b1, r1(), r1(), r6(), r6(), 3'd0, 8'h00, 7'b0);
  endtask

  task automatic trapRun();
    repeat (20) push(1'b0, r1(), r1(), r6(), r6(), 3'd5, 8'h00, 7'b0);
    resetDut(3'd5);
  endtask

  // Reference: phase sequence and strobes per instruction, with fw/mw memory wait cycles.
  task automatic runInstr(input int k, input int fw, input int mw, input logic z, input logic [5:0] io);
    logic [5:0] o, f;
    logic [1:0] j;
    int i;
    o = (k == ILL) ? io : opc[k];
    f = (k == NOP) ? nopFn() : (k <= JR) ? fnc[k] : r6();
    for (i = 0; i < fw && i <= MT; i++) push(1'b0, 1'b0, r1(), r6(), r6(), 3'd0, sb(1, 0, 0, 0, 0, 0, 2'b00), 7'b0);
    if (i > MT) begin
      trapRun();
      return;
    end
    push(1'b0, 1'b1, r1(), r6(), r6(), 3'd0, sb(1, 0, 1, 1, 0, 0, 2'b00), 7'b0);
    j = (k == JR) ? 2'b01 : (k == JAL) ? 2'b10 : 2'b00;
    push(1'b0, r1(), r1(), o, f, 3'd1, sb(0, 0, 0, k == JR || k == JAL, k == JAL, 0, j), 7'b0);
    if (k == ILL) begin
      trapRun();
      return;
    end
    if (k == JR || k == JAL || k == NOP) begin
      mRet++;
      return;
    end
    if (k == BEQ) begin
      push(1'b0, r1(), z, r6(), r6(), 3'd2, sb(0, 0, 0, z, 0, z, 2'b00), selT[k]);
      mRet++;
      return;
    end
    push(1'b0, r1(), r1(), r6(), r6(), 3'd2, 8'h00, selT[k]);
    if (k == LW || k == SW) begin
      for (i = 0; i < mw && i <= MT; i++) push(1'b0, 1'b0, r1(), r6(), r6(), 3'd3, sb(1, k == SW, 0, 0, 0, 0, 2'b00), selT[k]);
      if (i > MT) begin
        trapRun();
        return;
      end
      push(1'b0, 1'b1, r1(), r6(), r6(), 3'd3, sb(1, k == SW, 0, 0, 0, 0, 2'b00), selT[k]);
      if (k == SW) begin
        mRet++;
        return;
      end
    end
    push(1'b0, r1(), r1(), r6(), r6(), 3'd4, sb(0, 0, 0, 0, 1, 0, 2'b00), selT[k]);
    mRet++;
  endtask

  task automatic midReset(input int n);
    push(1'b0, 1'b1, r1(), r6(), r6(), 3'd0, sb(1, 0, 1, 1, 0, 0, 2'b00), 7'b0);
    push(1'b0, r1(), r1(), opc[LW], r6(), 3'd1, 8'h00, 7'b0);
    push(1'b0, r1(), r1(), r6(), r6(), 3'd2, 8'h00, selT[LW]);
    repeat (n) push(1'b0, 1'b0, r1(), r6(), r6(), 3'd3, sb(1, 0, 0, 0, 0, 0, 2'b00), selT[LW]);
    resetDut(3'd3);
  endtask

  // Monitor: every cycle with a queued expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      recT e;
      e = expQ.pop_front();
      chk("state", 32'(state), 32'(e.st));
      chk("strobes", 32'({mem_req, mem_we, ir_write, pc_write, reg_write, branch_taken, jump}), 32'(e.strb));
      if (e.chkSel) chk("selects", 32'({reg_dst, alu_src, ext_res, mem_to_reg, shf_to_reg, alu_op}), 32'(e.sl));
      chk("retired", 32'(retired), 32'(e.ret));
      chk("illegal", 32'(illegal), 32'(e.ill));
    end
  end

  initial begin
    int r, k;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = '0; func = '0;
    @(posedge clk);
    #1;
    push(1'b1, 1'b0, 1'b0, 6'h0, 6'h0, 3'd0, 8'h00, 7'b0);
    mRet = 0;
    runInstr(ADD, 0, 0, 1'b0, 6'h0);
    runInstr(LW, 0, 2, 1'b0, 6'h0);
    runInstr(BEQ, 0, 0, 1'b1, 6'h0);
    runInstr(BEQ, 1, 0, 1'b0, 6'h0);
    runInstr(SW, 4, 4, 1'b0, 6'h0);
    runInstr(JAL, 0, 0, 1'b0, 6'h0);
    runInstr(JR, 2, 0, 1'b0, 6'h0);
    resetDut(3'd0);
    repeat (5) runInstr(NOP, 0, 0, 1'b0, 6'h0);
    runInstr(ILL, 0, 0, 1'b0, 6'h3f);
    runInstr(ADD, MT + 5, 0, 1'b0, 6'h0);
    runInstr(LW, 0, MT + 1, 1'b0, 6'h0);
    midReset(2);
    repeat (300) begin
      r = $urandom_range(0, 99);
      if (r < 3) runInstr(ILL, 0, 0, 1'b0, illOp());
      else if (r < 6) begin
        k = $urandom_range(0, 2);
        if (k == 0) runInstr(ORI, MT + 1 + $urandom_range(0, 3), 0, 1'b0, 6'h0);
        else runInstr(k == 1 ? LW : SW, 0, MT + 1 + $urandom_range(0, 3), 1'b0, 6'h0);
      end else if (r < 9) midReset($urandom_range(1, 3));
      else runInstr($urandom_range(0, 9),
                    $urandom_range(0, 2) == 0 ? $urandom_range(0, MT) : 0,
                    $urandom_range(0, 2) == 0 ? $urandom_range(0, MT) : 0, r1(), 6'h0);
    end
    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      nChk++;
      nFail++;
      $display("FAIL drain: %0d expectations left, 0 required", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
